// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Issue controller for a registered ALU. Accepts one operation
//                at a time, latches and decodes its operands, strobes the ALU,
//                captures the registered result and holds it until the
//                downstream consumer takes it.
//                Optional feature macro: ALU_ISSUE_IMM_EN enables the
//                sign-extended 12-bit immediate as operand 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl (
    input  logic        soc_clk,
    input  logic        reset,
    // upstream operation handshake
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [11:0] in_imm,
    input  logic        in_imm_sel,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    // ALU side
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [2:0]  ALU_opcode,
    output logic [3:0]  decryptedOP,
    output logic        dat_ready,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    // downstream result handshake
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_overflow,
    output logic        res_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] w_op2;
    logic        w_sub_sel;
    logic [3:0]  w_decoded;

`ifdef ALU_ISSUE_IMM_EN
    // Immediate path: an immediate-form ADD never becomes SUB.
    always_comb begin
        w_op2     = in_imm_sel ? {{20{in_imm[11]}}, in_imm} : in_rs2;
        w_sub_sel = in_funct7b5 & ~in_imm_sel;
    end
`else
    // Immediate inputs are unused in this build; fold them into a sink.
    logic w_unused_imm;
    assign w_unused_imm = ^{in_imm, in_imm_sel};

    // Register-only path: operand 2 is always rs2.
    always_comb begin
        w_op2     = in_rs2;
        w_sub_sel = in_funct7b5;
    end
`endif

    // Map funct3 (plus modifiers) onto the ALU's internal op encoding.
    always_comb begin
        w_decoded = 4'd0;
        case (in_funct3)
            3'b000:  w_decoded = w_sub_sel ? 4'd7 : 4'd6;
            3'b001:  w_decoded = 4'd1;
            3'b010:  w_decoded = 4'd2;
            3'b011:  w_decoded = 4'd3;
            3'b100:  w_decoded = 4'd4;
            3'b101:  w_decoded = in_funct7b5 ? 4'd9 : 4'd8;
            3'b110:  w_decoded = 4'd5;
            default: w_decoded = 4'd0;
        endcase
    end

    // Issue FSM; every output is a register updated alongside the state.
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            in_ready     <= 1'b1;
            dat_ready    <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            ALU_dat1     <= 32'd0;
            ALU_dat2     <= 32'd0;
            ALU_opcode   <= 3'd0;
            decryptedOP  <= 4'd0;
            res_data     <= 32'd0;
            res_overflow <= 1'b0;
            res_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        ALU_dat1    <= in_rs1;
                        ALU_dat2    <= w_op2;
                        ALU_opcode  <= in_funct3;
                        decryptedOP <= w_decoded;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        dat_ready   <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // the ALU samples its operands during the single ISSUE cycle
                    dat_ready <= 1'b0;
                    r_state   <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    res_data     <= alu_result;
                    res_overflow <= alu_overflow;
                    res_zero     <= alu_zero;
                    res_valid    <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    dat_ready <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Self-checking bench for alu_issue_ctrl with a behavioural
//                registered ALU and a result scoreboard.
//                Honours ALU_ISSUE_IMM_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        soc_clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [11:0] in_imm;
    logic        in_imm_sel;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] ALU_dat1;
    logic [31:0] ALU_dat2;
    logic [2:0]  ALU_opcode;
    logic [3:0]  decryptedOP;
    logic        dat_ready;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_overflow;
    logic        res_zero;
    logic        busy;

    alu_issue_ctrl dut (
        .soc_clk      (soc_clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .in_imm_sel   (in_imm_sel),
        .in_funct3    (in_funct3),
        .in_funct7b5  (in_funct7b5),
        .ALU_dat1     (ALU_dat1),
        .ALU_dat2     (ALU_dat2),
        .ALU_opcode   (ALU_opcode),
        .decryptedOP  (decryptedOP),
        .dat_ready    (dat_ready),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .res_zero     (res_zero),
        .busy         (busy)
    );

    always #5 soc_clk = ~soc_clk;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] imm;
        logic        imm_sel;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  op;
        logic [31:0] dat2;
        logic [31:0] data;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        zero;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge soc_clk);
        #1;
    endtask

    task automatic set_inputs(input vec_t v);
        in_rs1      = v.rs1;
        in_rs2      = v.rs2;
        in_imm      = v.imm;
        in_imm_sel  = v.imm_sel;
        in_funct3   = v.f3;
        in_funct7b5 = v.f7;
    endtask

    // Behavioural registered ALU: samples operands while dat_ready is high.
    always @(posedge soc_clk) begin
        if (reset) begin
            alu_result   <= 32'd0;
            alu_overflow <= 1'b0;
            alu_zero     <= 1'b1;
        end else if (dat_ready) begin
            logic [31:0] r;
            logic        o;
            r = 32'd0;
            o = 1'b0;
            case (decryptedOP)
                4'd6: begin r = ALU_dat1 + ALU_dat2;
                            o = (ALU_dat1[31] == ALU_dat2[31]) && (r[31] != ALU_dat1[31]); end
                4'd7: begin r = ALU_dat1 - ALU_dat2;
                            o = (ALU_dat1[31] != ALU_dat2[31]) && (r[31] != ALU_dat1[31]); end
                4'd1: r = ALU_dat1 << ALU_dat2[4:0];
                4'd2: r = {31'd0, $signed(ALU_dat1) < $signed(ALU_dat2)};
                4'd3: r = {31'd0, ALU_dat1 < ALU_dat2};
                4'd4: r = ALU_dat1 ^ ALU_dat2;
                4'd8: r = ALU_dat1 >> ALU_dat2[4:0];
                4'd9: r = $signed(ALU_dat1) >>> ALU_dat2[4:0];
                4'd5: r = ALU_dat1 | ALU_dat2;
                default: r = ALU_dat1 & ALU_dat2;
            endcase
            alu_result   <= r;
            alu_overflow <= o;
            alu_zero     <= (r == 32'd0);
        end
    end

    // Scoreboard consumer: compares every delivered result in order.
    always @(negedge soc_clk) begin
        if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", res_data, mon_e.data);
                check("res_overflow", 32'(res_overflow), 32'(mon_e.ovf));
                check("res_zero", 32'(res_zero), 32'(mon_e.zero));
            end
        end
    end

    // One full operation with res_ready high throughout.
    task automatic run_vec(input vec_t v);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        set_inputs(v);
        in_valid = 1'b1;
        step;
        sb.push_back('{v.data, v.ovf, v.zero});
        in_valid = 1'b0;
        check("issue_dat_ready", 32'(dat_ready), 32'd1);
        check("decryptedOP", 32'(decryptedOP), 32'(v.op));
        check("ALU_dat1", ALU_dat1, v.rs1);
        check("ALU_dat2", ALU_dat2, v.dat2);
        check("ALU_opcode", 32'(ALU_opcode), 32'(v.f3));
        check("issue_busy", 32'(busy), 32'd1);
        step;
        check("capture_dat_ready", 32'(dat_ready), 32'd0);
        check("capture_res_valid", 32'(res_valid), 32'd0);
        step;
        check("resp_res_valid", 32'(res_valid), 32'd1);
        check("resp_in_ready", 32'(in_ready), 32'd0);
        step;
        check("post_res_valid", 32'(res_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int acc;
        int pulses;
        int last;
        int rv;

        //              rs1           rs2           imm      sel  f3      f7    op     dat2          data          ovf   zero
        vecs[0]  = '{32'd5,        32'd3,        12'd0,   1'b0, 3'b000, 1'b0, 4'd6, 32'd3,        32'd8,        1'b0, 1'b0};
        vecs[1]  = '{32'd3,        32'd3,        12'd0,   1'b0, 3'b000, 1'b1, 4'd7, 32'd3,        32'd0,        1'b0, 1'b1};
        vecs[2]  = '{32'h7FFFFFFF, 32'd1,        12'd0,   1'b0, 3'b000, 1'b0, 4'd6, 32'd1,        32'h80000000, 1'b1, 1'b0};
        vecs[3]  = '{32'd1,        32'd4,        12'd0,   1'b0, 3'b001, 1'b0, 4'd1, 32'd4,        32'd16,       1'b0, 1'b0};
        vecs[4]  = '{32'hFFFFFFFF, 32'd1,        12'd0,   1'b0, 3'b010, 1'b0, 4'd2, 32'd1,        32'd1,        1'b0, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'd1,        12'd0,   1'b0, 3'b011, 1'b0, 4'd3, 32'd1,        32'd0,        1'b0, 1'b1};
        vecs[6]  = '{32'hF0F0F0F0, 32'h0F0F0F0F, 12'd0,   1'b0, 3'b100, 1'b0, 4'd4, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[7]  = '{32'h80000000, 32'd4,        12'd0,   1'b0, 3'b101, 1'b0, 4'd8, 32'd4,        32'h08000000, 1'b0, 1'b0};
        vecs[8]  = '{32'h80000000, 32'd4,        12'd0,   1'b0, 3'b101, 1'b1, 4'd9, 32'd4,        32'hF8000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h000000F0, 32'h00000F00, 12'd0,   1'b0, 3'b110, 1'b0, 4'd5, 32'h00000F00, 32'h00000FF0, 1'b0, 1'b0};
        vecs[10] = '{32'hFF00FF00, 32'h0F0F0F0F, 12'd0,   1'b0, 3'b111, 1'b0, 4'd0, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0};
`ifdef ALU_ISSUE_IMM_EN
        vecs[11] = '{32'h10,       32'd5,        12'hFFF, 1'b1, 3'b000, 1'b1, 4'd6, 32'hFFFFFFFF, 32'h0000000F, 1'b0, 1'b0};
`else
        vecs[11] = '{32'h10,       32'd5,        12'hFFF, 1'b1, 3'b000, 1'b1, 4'd7, 32'd5,        32'h0000000B, 1'b0, 1'b0};
`endif

        reset       = 1'b1;
        in_valid    = 1'b0;
        res_ready   = 1'b1;
        in_rs1      = 32'd0;
        in_rs2      = 32'd0;
        in_imm      = 12'd0;
        in_imm_sel  = 1'b0;
        in_funct3   = 3'd0;
        in_funct7b5 = 1'b0;
        repeat (3) step;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_dat_ready", 32'(dat_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_ALU_dat1", ALU_dat1, 32'd0);
        check("rst_decryptedOP", 32'(decryptedOP), 32'd0);
        reset = 1'b0;
        step;

        // Table-driven single operations
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Backpressure: result held for 10 cycles, a second request is ignored
        res_ready = 1'b0;
        set_inputs(vecs[0]);
        in_valid = 1'b1;
        step;
        sb.push_back('{32'd8, 1'b0, 1'b0});
        in_valid = 1'b0;
        step;
        step;
        for (int k = 0; k < 10; k++) begin
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_res_data", res_data, 32'd8);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            if (k == 2) begin
                in_rs1   = 32'd100;
                in_rs2   = 32'd1;
                in_valid = 1'b1;
            end
            if (k == 8) in_valid = 1'b0;
            step;
        end
        check("hold_ALU_dat1_kept", ALU_dat1, 32'd5);
        check("hold_decryptedOP_kept", 32'(decryptedOP), 32'd6);
        res_ready = 1'b1;
        step;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_res_valid", 32'(res_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);

        // Reset during CAPTURE discards the operation
        set_inputs(vecs[1]);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        check("midrst_pre_res_valid", 32'(res_valid), 32'd0);
        reset = 1'b1;
        step;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_dat_ready", 32'(dat_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_res_data", res_data, 32'd0);
        check("midrst_decryptedOP", 32'(decryptedOP), 32'd0);
        reset = 1'b0;
        rv = 0;
        repeat (6) begin
            step;
            if (res_valid) rv++;
        end
        check("midrst_no_result", 32'(rv), 32'd0);

        // Back-to-back requests: one accept every 4 cycles
        set_inputs(vecs[0]);
        in_valid = 1'b1;
        acc    = 0;
        pulses = 0;
        last   = -1;
        for (int c = 0; c < 16; c++) begin
            if (in_ready) begin
                if (last >= 0) check("b2b_interval", 32'(c - last), 32'd4);
                last = c;
                acc++;
                sb.push_back('{32'd8, 1'b0, 1'b0});
            end
            if (dat_ready) pulses++;
            step;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd4);
        check("b2b_dat_ready_pulses", 32'(pulses), 32'd4);
        step;
        check("b2b_end_in_ready", 32'(in_ready), 32'd1);

        step;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameters: none; all widths fixed (32-bit datapath, 12-bit immediate).
REQ-002 soc_clk  input  1  block clock, all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 in_valid / in_ready  input / output  1 / 1  upstream operation handshake; transfer when both high at a rising edge.
REQ-005 in_rs1, in_rs2  input  32 each  register operands.
REQ-006 in_imm  input  12  immediate operand, two's complement.
REQ-007 in_imm_sel  input  1  1 = operand 2 taken from in_imm.
REQ-008 in_funct3  input  3  operation class; in_funct7b5  input  1  alternate-op modifier.
REQ-009 ALU_dat1, ALU_dat2  output  32 each  operands to the ALU.
REQ-010 ALU_opcode  output  3  latched funct3; decryptedOP  output  4  decoded op; dat_ready  output  1  ALU sample strobe.
REQ-011 alu_result  input  32; alu_overflow, alu_zero  input  1 each  registered ALU outputs.
REQ-012 res_valid / res_ready  output / input  1 / 1  downstream result handshake.
REQ-013 res_data  output  32; res_overflow, res_zero  output  1 each; busy  output  1  high in any state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP; in_ready SHALL be high only in IDLE.
REQ-015 IDLE: on in_valid&in_ready, latch operands, funct3, decoded op; next state ISSUE; otherwise remain IDLE.
REQ-016 ISSUE: dat_ready SHALL be high for exactly this one cycle; next state CAPTURE unconditionally.
REQ-017 CAPTURE: alu_result/alu_overflow/alu_zero SHALL be registered into res_data/res_overflow/res_zero at the cycle-end edge; next state RESP.
REQ-018 RESP: res_valid high; on res_ready high, next state IDLE; while res_ready low, res_* SHALL hold stable.
REQ-019 Latency: res_valid SHALL rise exactly 3 cycles after the accepting edge; minimum issue interval 4 cycles.
REQ-020 in_valid asserted outside IDLE SHALL be ignored (no latch, no state change).
REQ-021 ALU_dat1, ALU_dat2, ALU_opcode, decryptedOP SHALL hold the last latched values until the next accept.
REQ-022 Decode (funct3 -> decryptedOP): 000 -> 6 (ADD), or 7 (SUB) when funct7b5=1 and in_imm_sel=0; 001 -> 1; 010 -> 2; 011 -> 3; 100 -> 4; 101 -> 8, or 9 when funct7b5=1; 110 -> 5; 111 -> 0.
REQ-023 Operand 2 SHALL be in_rs2 when in_imm_sel=0, else in_imm sign-extended to 32 bits (subject to REQ-027).
REQ-024 res_valid and in_ready SHALL never be high in the same cycle.

Reset
REQ-025 On reset the FSM SHALL enter IDLE and all outputs SHALL be 0 except in_ready=1, in every state including mid-operation.
REQ-026 An operation interrupted by reset SHALL be discarded; no res_valid SHALL follow it.

Configuration
REQ-027 Macro ALU_ISSUE_IMM_EN: defined -> immediate path per REQ-023; undefined -> in_imm and in_imm_sel ignored, operand 2 always in_rs2, SUB decode depends on funct7b5 only.

Verification
REQ-028 rs1=5, rs2=3, funct3=000, f7b5=0 accepted -> dat_ready one pulse next cycle, decryptedOP=6, res_data=8, res_zero=0, res_valid 3 cycles after accept.
REQ-029 rs1=3, rs2=3, funct3=000, f7b5=1, imm_sel=0 -> decryptedOP=7, res_data=0, res_zero=1.
REQ-030 With ALU_ISSUE_IMM_EN: rs1=0x10, imm=0xFFF, imm_sel=1, f7b5=1 -> ALU_dat2=0xFFFFFFFF, decryptedOP=6, res_data=0xF; without macro same stimulus -> ALU_dat2=rs2, decryptedOP=7.
REQ-031 res_ready held low 10 cycles in RESP -> res_valid and res_data stable, in_ready low, second in_valid ignored; res_ready high -> IDLE next cycle.
REQ-032 reset asserted in CAPTURE -> next cycle IDLE, in_ready=1, res_valid=0, dat_ready=0, no result delivered.
REQ-033 Back-to-back in_valid held high with res_ready=1 -> accepts exactly every 4 cycles, one dat_ready pulse per op.
